// File: rtl/hp_mul_pipe_pkg.sv
// Shared FPU definitions for the binary16 multiplier pipeline.
// Field widths, special encodings, flag indices and stage bundles.
package hp_mul_pipe_pkg;

    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 10;
    localparam int SIG_W    = FRAC_W + 1;
    localparam int PROD_W   = 2 * SIG_W;
    localparam int ES_W     = 7;
    localparam int EXP_BIAS = 15;

    localparam logic [15:0] QNAN_CANON = 16'h7E00;
    localparam logic [15:0] POS_INF    = 16'h7C00;

    localparam int INV = 3;
    localparam int OVF = 2;
    localparam int UNF = 1;
    localparam int INX = 0;

    typedef struct packed {
        logic inf;
        logic zero;
        logic snan;
        logic qnan;
        logic normal;
        logic subnormal;
    } cls_t;

    typedef struct packed {
        logic                   sign;
        logic [SIG_W-1:0]       ma;
        logic [SIG_W-1:0]       mb;
        logic signed [ES_W-1:0] es;
        logic                   spec;
        logic [15:0]            spec_y;
        logic                   inv;
    } s1_t;

    typedef struct packed {
        logic                   sign;
        logic [PROD_W-1:0]      p;
        logic signed [ES_W-1:0] es;
        logic                   spec;
        logic [15:0]            spec_y;
        logic                   inv;
    } s2_t;

endpackage

// File: rtl/hp_mul_pipe_if.sv
// Operand/result handshake bundle for the binary16 multiplier.
// The producer/consumer side uses master, the multiplier uses slave.
interface hp_mul_pipe_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic [3:0]  flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, flags
    );

endinterface

// File: rtl/hp_mul_pipe_cls.sv
// FP16 operand classifier: splits an unsigned binary16 magnitude
// into inf/zero/snan/qnan/normal/subnormal one-hot flags.
module hp_mul_pipe_cls
    import hp_mul_pipe_pkg::*;
(
    input  logic [14:0] x,
    output cls_t        cls
);

    logic exp_max;
    logic exp_min;
    logic frac_nz;

    assign exp_max = &x[14:10];
    assign exp_min = ~|x[14:10];
    assign frac_nz = |x[9:0];

    assign cls.inf       = exp_max & ~frac_nz;
    assign cls.snan      = exp_max & frac_nz & ~x[9];
    assign cls.qnan      = exp_max & x[9];
    assign cls.zero      = exp_min & ~frac_nz;
    assign cls.subnormal = exp_min & frac_nz;
    assign cls.normal    = ~exp_max & ~exp_min;

endmodule

// File: rtl/hp_mul_pipe.sv
// Three-stage binary16 multiplier: classify, multiply, round/pack.
// RNE rounding, DAZ on inputs, FTZ on results, one global stall.
module hp_mul_pipe #(
    parameter logic [15:0] QNAN_CANON = hp_mul_pipe_pkg::QNAN_CANON
) (
    input  logic          clk,
    input  logic          rst_n,
    hp_mul_pipe_if.slave  bus
);
    import hp_mul_pipe_pkg::*;

    cls_t ca;
    cls_t cb;

    hp_mul_pipe_cls u_cls_a (.x(bus.a[14:0]), .cls(ca));
    hp_mul_pipe_cls u_cls_b (.x(bus.b[14:0]), .cls(cb));

    logic        en;
    logic        v1_q;
    logic        v2_q;
    logic        ov_q;
    logic [15:0] y_q;
    logic [3:0]  fl_q;
    s1_t         s1_d;
    s1_t         s1_q;
    s2_t         s2_d;
    s2_t         s2_q;

    assign en           = ~ov_q | bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = ov_q;
    assign bus.y        = y_q;
    assign bus.flags    = fl_q;

    logic za;
    logic zb;
    logic any_nan;
    logic inf_zero;
    logic r_nan;
    logic r_inf;

    assign za       = ca.zero | ca.subnormal;
    assign zb       = cb.zero | cb.subnormal;
    assign any_nan  = ca.snan | ca.qnan | cb.snan | cb.qnan;
    assign inf_zero = (ca.inf & zb) | (cb.inf & za);
    assign r_nan    = any_nan | inf_zero;
    assign r_inf    = ~r_nan & (ca.inf | cb.inf);

    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.a[15] ^ bus.b[15];
        s1_d.ma   = {1'b1, bus.a[9:0]};
        s1_d.mb   = {1'b1, bus.b[9:0]};
        s1_d.es   = $signed({2'b00, bus.a[14:10]})
                  + $signed({2'b00, bus.b[14:10]})
                  - 7'(EXP_BIAS);
        s1_d.spec = ~(ca.normal & cb.normal);
        unique case (1'b1)
            r_nan: begin
                s1_d.spec_y = QNAN_CANON;
                s1_d.inv    = ca.snan | cb.snan | inf_zero;
            end
            r_inf: s1_d.spec_y = {s1_d.sign, POS_INF[14:0]};
            default: s1_d.spec_y = {s1_d.sign, 15'h0};
        endcase
    end

    always_comb begin
        s2_d        = '0;
        s2_d.sign   = s1_q.sign;
        s2_d.p      = {11'b0, s1_q.ma} * {11'b0, s1_q.mb};
        s2_d.es     = s1_q.es;
        s2_d.spec   = s1_q.spec;
        s2_d.spec_y = s1_q.spec_y;
        s2_d.inv    = s1_q.inv;
    end

    logic signed [ES_W-1:0] e;
    logic [9:0]  frac;
    logic        grd;
    logic        stk;
    logic        inc;
    logic [10:0] fr;
    logic [15:0] y_d;
    logic [3:0]  fl_d;

    always_comb begin
        e = s2_q.es;
        if (s2_q.p[21]) begin
            frac = s2_q.p[20:11];
            grd  = s2_q.p[10];
            stk  = |s2_q.p[9:0];
            e    = e + 7'sd1;
        end else begin
            frac = s2_q.p[19:10];
            grd  = s2_q.p[9];
            stk  = |s2_q.p[8:0];
        end
        inc = grd & (stk | frac[0]);
        // Carry out of the fraction means 1.11..1 rounded up to 10.0.
        fr  = {1'b0, frac} + {10'b0, inc};
        if (fr[10]) e = e + 7'sd1;
        y_d  = '0;
        fl_d = '0;
        if (s2_q.spec) begin
            y_d       = s2_q.spec_y;
            fl_d[INV] = s2_q.inv;
        end else if (e >= 7'sd31) begin
            y_d       = {s2_q.sign, POS_INF[14:0]};
            fl_d[OVF] = 1'b1;
            fl_d[INX] = 1'b1;
        end else if (e <= 7'sd0) begin
            y_d       = {s2_q.sign, 15'h0};
            fl_d[UNF] = 1'b1;
            fl_d[INX] = 1'b1;
        end else begin
            y_d       = {s2_q.sign, e[4:0], fr[9:0]};
            fl_d[INX] = grd | stk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            ov_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            y_q  <= '0;
            fl_q <= '0;
        end else if (en) begin
            v1_q <= bus.in_valid;
            s1_q <= s1_d;
            v2_q <= v1_q;
            s2_q <= s2_d;
            ov_q <= v2_q;
            if (v2_q) begin
                y_q  <= y_d;
                fl_q <= fl_d;
            end
        end
    end

endmodule

// File: tb/tb_hp_mul_pipe.sv
// Self-checking bench for hp_mul_pipe: directed corner cases,
// stall/order stream, async reset, and a randomized scoreboard run.
module tb_hp_mul_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hp_mul_pipe_if bus ();

    hp_mul_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_out  = 0;

    logic [19:0] exp_q[$];
    int          acc_q[$];
    bit          lat_q[$];

    bit          hold_prev = 0;
    logic [15:0] hold_y;
    logic [3:0]  hold_fl;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    function automatic logic [19:0] ref_mul(input logic [15:0] a,
                                            input logic [15:0] b);
        int ea, eb, fa, fb, e, sh;
        longint p, q, rem, half;
        bit s, an, bn, asn, bsn, ai, bi, az, bz, iz, up;
        ea  = int'(a[14:10]);
        eb  = int'(b[14:10]);
        fa  = int'(a[9:0]);
        fb  = int'(b[9:0]);
        s   = a[15] ^ b[15];
        an  = (ea == 31) && (fa != 0);
        bn  = (eb == 31) && (fb != 0);
        asn = an && !a[9];
        bsn = bn && !b[9];
        ai  = (ea == 31) && (fa == 0);
        bi  = (eb == 31) && (fb == 0);
        az  = (ea == 0);
        bz  = (eb == 0);
        iz  = (ai && bz) || (bi && az);
        if (an || bn || iz)
            return {(asn || bsn || iz) ? 4'b1000 : 4'b0000, 16'h7E00};
        if (ai || bi) return {4'b0000, s, 15'h7C00};
        if (az || bz) return {4'b0000, s, 15'h0000};
        p    = longint'(1024 + fa) * longint'(1024 + fb);
        sh   = (p >= (longint'(1) << 21)) ? 11 : 10;
        e    = ea + eb - 15 + (sh - 10);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        up   = (rem > half) || ((rem == half) && q[0]);
        if (up) q = q + 1;
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
        if (e >= 31) return {4'b0101, s, 15'h7C00};
        if (e <= 0)  return {4'b0011, s, 15'h0000};
        return {3'b000, rem != 0, s, 5'(e), 10'(q - 1024)};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 9))
            0: r[14:10] = 5'd0;
            1: r[14:0] = 15'h7C00;
            2: begin
                r[14:10] = 5'h1F;
                if (r[9:0] == 10'd0) r[0] = 1'b1;
            end
            default:
                if (r[14:10] == 5'd0 || r[14:10] == 5'h1F)
                    r[14:10] = 5'd15;
        endcase
        return r;
    endfunction

    task automatic step(input bit iv,
                        input logic [15:0] xa,
                        input logic [15:0] xb,
                        input bit ordy,
                        input logic [19:0] want,
                        input bit lat,
                        output bit acc);
        logic [19:0] e;
        int ac;
        bit l;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = xa;
        bus.b         = xb;
        bus.out_ready = ordy;
        #1;
        cyc++;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", exp_q.size(), 1);
            end else begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                l  = lat_q.pop_front();
                chk("y", bus.y, e[15:0]);
                chk("flags", bus.flags, e[19:16]);
                if (l) chk("latency", cyc - ac, 3);
                n_out++;
            end
        end
        if (bus.out_valid && !bus.out_ready)
            chk("in_ready_stall", bus.in_ready, 0);
        if (hold_prev) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_y", bus.y, hold_y);
            chk("hold_flags", bus.flags, hold_fl);
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        hold_y    = bus.y;
        hold_fl   = bus.flags;
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            exp_q.push_back(want);
            acc_q.push_back(cyc);
            lat_q.push_back(lat);
        end
    endtask

    task automatic send(input logic [15:0] xa,
                        input logic [15:0] xb,
                        input logic [19:0] want,
                        input bit lat);
        bit acc;
        int tries;
        tries = 0;
        acc = 0;
        while (!acc && tries < 50) begin
            step(1'b1, xa, xb, 1'b1, want, lat, acc);
            tries++;
        end
        if (!acc) chk("send_accept", 0, 1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step(1'b0, 16'h0, 16'h0, 1'b1, 20'h0, 1'b0, acc);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    logic [15:0] da[9] = '{16'h3C00, 16'h4000, 16'h3C01, 16'h7BFF,
                           16'h0400, 16'h7C00, 16'h7D00, 16'h7E00,
                           16'hFC00};
    logic [15:0] db[9] = '{16'h3C00, 16'h4200, 16'h3C01, 16'h4000,
                           16'h0400, 16'h0000, 16'h3C00, 16'h3C00,
                           16'h3C00};
    logic [19:0] dw[9] = '{20'h03C00, 20'h04600, 20'h13C02, 20'h57C00,
                           20'h30000, 20'h87E00, 20'h87E00, 20'h07E00,
                           20'h0FC00};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int i;
        int k;
        int base;
        logic [15:0] sa[6];
        logic [15:0] sb[6];
        logic [15:0] ra;
        logic [15:0] rb;

        bus.in_valid  = 1'b0;
        bus.a         = 16'h0;
        bus.b         = 16'h0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y, 16'h0000);
        chk("rst_flags", bus.flags, 4'h0);
        chk("rst_in_ready", bus.in_ready, 1);

        send(da[0], db[0], dw[0], 1'b1);
        drain();
        for (int j = 1; j < 9; j++) send(da[j], db[j], dw[j], 1'b0);
        drain();

        for (int j = 0; j < 6; j++) begin
            sa[j] = {1'($urandom), 5'($urandom_range(10, 20)),
                     10'($urandom)};
            sb[j] = {1'($urandom), 5'($urandom_range(10, 20)),
                     10'($urandom)};
        end
        i = 0;
        k = 0;
        while (i < 6 && k < 40) begin
            step(1'b1, sa[i], sb[i], !(k >= 3 && k < 7),
                 ref_mul(sa[i], sb[i]), 1'b0, acc);
            if (acc) i++;
            k++;
        end
        chk("stream_sent", i, 6);
        drain();

        base = n_out;
        step(1'b1, 16'h4000, 16'h4000, 1'b1, 20'h04400, 1'b0, acc);
        step(1'b1, 16'h4200, 16'h4000, 1'b1, 20'h04600, 1'b0, acc);
        step(1'b0, 16'h0, 16'h0, 1'b1, 20'h0, 1'b0, acc);
        step(1'b0, 16'h0, 16'h0, 1'b0, 20'h0, 1'b0, acc);
        chk("pre_rst_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_y", bus.y, 16'h0000);
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        hold_prev = 0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = n_out;
        send(16'h3C00, 16'h4200, 20'h04200, 1'b1);
        for (int j = 0; j < 8; j++)
            step(1'b0, 16'h0, 16'h0, 1'b1, 20'h0, 1'b0, acc);
        chk("post_rst_count", n_out - base, 1);

        for (int j = 0; j < 400; j++) begin
            ra = rand_op();
            rb = rand_op();
            i = 0;
            acc = 0;
            while (!acc && i < 50) begin
                step(1'b1, ra, rb, ($urandom_range(0, 3) != 0),
                     ref_mul(ra, rb), 1'b0, acc);
                i++;
            end
            if (!acc) chk("rand_accept", 0, 1);
            if ($urandom_range(0, 7) == 0)
                step(1'b0, 16'h0, 16'h0, 1'b1, 20'h0, 1'b0, acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
